// File: rtl/cla_mwadd_pkg.sv
// Shared types and helpers for the sequenced multi-word carry-lookahead adder.
package cla_mwadd_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} cla_mwadd_state_t;

    localparam int NIBBLE_W = 4;

    function automatic int cnt_width(int nib);
        return (nib <= 1) ? 1 : $clog2(nib);
    endfunction

endpackage

// File: rtl/carry_lookahead_adder_4b.sv
// 4-bit carry-lookahead adder: one nibble of the multi-word datapath.
module carry_lookahead_adder_4b (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[3:0];
    assign cout = c[4];

endmodule

// File: rtl/cla_multiword_add_seq.sv
// WIDTH-bit adder built from one 4-bit CLA, one nibble per cycle, LSB first.
// Optional subtract mode (extra `sub` port) when CLA_MWADD_SUB_EN is defined.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// RUN   | adding one nibble per cycle, carry held in carry_q
// DONE  | result on sum/cout, out_valid high until out_ready
module cla_multiword_add_seq
    import cla_mwadd_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_MWADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NIB = WIDTH / NIBBLE_W;
    localparam int CW  = cnt_width(NIB);
    localparam logic [CW-1:0] CNT_LAST = CW'(NIB - 1);

    if ((WIDTH < NIBBLE_W) || ((WIDTH % NIBBLE_W) != 0)) begin : g_bad_width
        $error("cla_multiword_add_seq: WIDTH must be a multiple of 4 and >= 4");
    end

    cla_mwadd_state_t state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             sub_i;
    logic [3:0]       add_sum;
    logic             add_cout;
    logic [WIDTH-1:0] sum_full;

`ifdef CLA_MWADD_SUB_EN
    assign sub_i = sub;
`else
    assign sub_i = 1'b0;
`endif

    carry_lookahead_adder_4b u_cla (
        .a    (a_sh_q[NIBBLE_W-1:0]),
        .b    (b_sh_q[NIBBLE_W-1:0]),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Earlier nibbles live below the current adder output; a single-nibble
    // build needs no shift register at all.
    if (NIB > 1) begin : g_sum_sh
        logic [WIDTH-NIBBLE_W-1:0] sum_sh_q, sum_sh_d;

        assign sum_full = {add_sum, sum_sh_q};

        always_comb begin
            sum_sh_d = sum_sh_q;
            if (state_q == RUN) begin
                sum_sh_d = sum_full[WIDTH-1:NIBBLE_W];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_sh_q <= '0;
            end else begin
                sum_sh_q <= sum_sh_d;
            end
        end
    end else begin : g_no_sum_sh
        assign sum_full = add_sum;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtract is a + ~b + 1: invert b and the incoming carry.
                    a_sh_d  = a;
                    b_sh_d  = b ^ {WIDTH{sub_i}};
                    carry_d = cin ^ sub_i;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                carry_d = add_cout;
                a_sh_d  = a_sh_q >> NIBBLE_W;
                b_sh_d  = b_sh_q >> NIBBLE_W;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    sum_d   = sum_full;
                    cout_d  = add_cout;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_cla_multiword_add_seq.sv
// Directed and random checks of cla_multiword_add_seq at WIDTH 16, 4 and 32.
module tb_cla_multiword_add_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    logic        in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
    logic [15:0] a, b, sum;

    logic        in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4, busy4;
    logic [3:0]  a4, b4, sum4;

    logic        in_valid32, in_ready32, cin32, out_valid32, out_ready32, cout32, busy32;
    logic [31:0] a32, b32, sum32;

`ifdef CLA_MWADD_SUB_EN
    logic sub;
    logic sub_x;
`endif

    int hs16 = 0;
    int hs4  = 0;
    int hs32 = 0;

    always @(posedge clk) begin
        if (out_valid && out_ready)     hs16 <= hs16 + 1;
        if (out_valid4 && out_ready4)   hs4  <= hs4 + 1;
        if (out_valid32 && out_ready32) hs32 <= hs32 + 1;
    end

    cla_multiword_add_seq #(.WIDTH(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
`ifdef CLA_MWADD_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .busy(busy)
    );

    cla_multiword_add_seq #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4),
`ifdef CLA_MWADD_SUB_EN
        .sub(sub_x),
`endif
        .out_valid(out_valid4), .out_ready(out_ready4), .sum(sum4), .cout(cout4), .busy(busy4)
    );

    cla_multiword_add_seq #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .cin(cin32),
`ifdef CLA_MWADD_SUB_EN
        .sub(sub_x),
`endif
        .out_valid(out_valid32), .out_ready(out_ready32), .sum(sum32), .cout(cout32), .busy(busy32)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand pair for one accept edge, then scramble the inputs.
    task automatic send16(input logic [15:0] av, input logic [15:0] bv, input logic c);
        in_valid = 1'b1;
        a = av;
        b = bv;
        cin = c;
        tick();
        in_valid = 1'b0;
        a = ~av;
        b = 16'($urandom);
        cin = ~c;
    endtask

    task automatic wait16(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 0; a = '0; b = '0; cin = 0; out_ready = 0;
        in_valid4 = 0; a4 = '0; b4 = '0; cin4 = 0; out_ready4 = 0;
        in_valid32 = 0; a32 = '0; b32 = '0; cin32 = 0; out_ready32 = 0;
`ifdef CLA_MWADD_SUB_EN
        sub = 0;
        sub_x = 0;
`endif
        #2;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: in_ready=%b out_valid=%b busy=%b expected 1 0 0", in_ready, out_valid, busy);
        end
        checks++;
        if (sum !== 16'h0000 || cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_result: sum=%h cout=%b expected 0000 0", sum, cout);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_carry_ripple();
        int n;
        out_ready = 1'b1;
        send16(16'hFFFF, 16'h0001, 1'b0);
        wait16(n);
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL ripple_latency: cycles=%0d expected 4", n);
        end
        checks++;
        if (sum !== 16'h0000 || cout !== 1'b1) begin
            errors++;
            $display("FAIL ripple_result: sum=%h cout=%b expected 0000 1", sum, cout);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ripple_release: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
        end
        checks++;
        if (sum !== 16'h0000 || cout !== 1'b1) begin
            errors++;
            $display("FAIL ripple_hold_idle: sum=%h cout=%b expected 0000 1", sum, cout);
        end
    endtask

    task automatic test_carry_in();
        int n;
        out_ready = 1'b1;
        send16(16'h1234, 16'h4321, 1'b1);
        wait16(n);
        checks++;
        if (n >= 200 || sum !== 16'h5556 || cout !== 1'b0) begin
            errors++;
            $display("FAIL carry_in: sum=%h cout=%b expected 5556 0", sum, cout);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int n;
        out_ready = 1'b0;
        send16(16'h8000, 16'h8000, 1'b0);
        wait16(n);
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL bp_latency: cycles=%0d expected 4", n);
        end
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            a = 16'h0003;
            b = 16'h0004;
            cin = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || sum !== 16'h0000 || cout !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold: cycle=%0d out_valid=%b sum=%h cout=%b in_ready=%b expected 1 0000 1 0",
                         i, out_valid, sum, cout, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b busy=%b expected 1 0 0", in_ready, out_valid, busy);
        end
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_next_accept: busy=%b expected 1", busy);
        end
        in_valid = 1'b0;
        wait16(n);
        checks++;
        if (n >= 200 || sum !== 16'h0007 || cout !== 1'b0) begin
            errors++;
            $display("FAIL bp_next_result: sum=%h cout=%b expected 0007 0", sum, cout);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        int n;
        out_ready = 1'b1;
        send16(16'h00FF, 16'h0001, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_flags: out_valid=%b busy=%b in_ready=%b expected 0 0 1", out_valid, busy, in_ready);
        end
        checks++;
        if (sum !== 16'h0000 || cout !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_result: sum=%h cout=%b expected 0000 0", sum, cout);
        end
        tick();
        rst_n = 1'b1;
        tick();
        send16(16'h0001, 16'h0001, 1'b0);
        wait16(n);
        checks++;
        if (n != 4 || sum !== 16'h0002 || cout !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_next: cycles=%0d sum=%h cout=%b expected 4 0002 0", n, sum, cout);
        end
        tick();
    endtask

`ifdef CLA_MWADD_SUB_EN
    task automatic test_sub();
        int n;
        logic [15:0] av [3] = '{16'h0005, 16'h0009, 16'h0005};
        logic [15:0] bv [3] = '{16'h0007, 16'h0003, 16'h0007};
        logic        sv [3] = '{1'b1, 1'b1, 1'b0};
        logic [15:0] es [3] = '{16'hFFFE, 16'h0006, 16'h000C};
        logic        ec [3] = '{1'b0, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sub = sv[i];
            send16(av[i], bv[i], 1'b0);
            sub = ~sv[i];
            wait16(n);
            checks++;
            if (n >= 200 || sum !== es[i] || cout !== ec[i]) begin
                errors++;
                $display("FAIL sub_%0d: sum=%h cout=%b expected %h %b", i, sum, cout, es[i], ec[i]);
            end
            tick();
        end
        sub = 1'b0;
    endtask
`endif

    task automatic test_back_to_back16();
        logic [15:0] av, bv;
        logic        c;
        logic [16:0] e;
        int          n, first, hs0;
        hs0 = hs16;
        for (int k = 0; k < 25; k++) begin
            n = 0;
            while (in_ready !== 1'b1 && n < 50) begin
                tick();
                n++;
            end
            av = 16'($urandom);
            bv = 16'($urandom);
            c  = 1'($urandom);
            e  = {1'b0, av} + {1'b0, bv} + {16'b0, c};
            send16(av, bv, c);
            n = 0;
            first = -1;
            while (n < 200) begin
                out_ready = 1'($urandom);
                in_valid = 1'($urandom);
                a = 16'($urandom);
                if (out_valid === 1'b1) begin
                    if (first < 0) first = n;
                    if (out_ready) break;
                end
                tick();
                n++;
            end
            in_valid = 1'b0;
            checks++;
            if (first != 4) begin
                errors++;
                $display("FAIL b2b16_latency: txn=%0d cycles=%0d expected 4", k, first);
            end
            checks++;
            if ({cout, sum} !== e) begin
                errors++;
                $display("FAIL b2b16_result: txn=%0d got=%h expected %h", k, {cout, sum}, e);
            end
            tick();
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL b2b16_dup: txn=%0d out_valid=%b busy=%b expected 0 0", k, out_valid, busy);
            end
        end
        out_ready = 1'b1;
        checks++;
        if (hs16 - hs0 != 25) begin
            errors++;
            $display("FAIL b2b16_count: handshakes=%0d expected 25", hs16 - hs0);
        end
    endtask

    task automatic test_width4();
        logic [3:0] av, bv;
        logic       c;
        logic [4:0] e;
        int         n, first, hs0;
        hs0 = hs4;
        for (int k = 0; k < 12; k++) begin
            av = (k == 0) ? 4'hF : 4'($urandom);
            bv = (k == 0) ? 4'h1 : 4'($urandom);
            c  = (k == 0) ? 1'b0 : 1'($urandom);
            e  = {1'b0, av} + {1'b0, bv} + {4'b0, c};
            in_valid4 = 1'b1; a4 = av; b4 = bv; cin4 = c;
            tick();
            in_valid4 = 1'b0; a4 = ~av; cin4 = ~c;
            n = 0;
            first = -1;
            while (n < 100) begin
                out_ready4 = 1'($urandom);
                if (out_valid4 === 1'b1) begin
                    if (first < 0) first = n;
                    if (out_ready4) break;
                end
                tick();
                n++;
            end
            checks++;
            if (first != 1 || {cout4, sum4} !== e) begin
                errors++;
                $display("FAIL w4_txn: txn=%0d cycles=%0d got=%h expected 1 %h", k, first, {cout4, sum4}, e);
            end
            tick();
            checks++;
            if (out_valid4 !== 1'b0 || busy4 !== 1'b0 || in_ready4 !== 1'b1) begin
                errors++;
                $display("FAIL w4_dup: txn=%0d out_valid=%b busy=%b in_ready=%b expected 0 0 1",
                         k, out_valid4, busy4, in_ready4);
            end
        end
        checks++;
        if (hs4 - hs0 != 12) begin
            errors++;
            $display("FAIL w4_count: handshakes=%0d expected 12", hs4 - hs0);
        end
    endtask

    task automatic test_width32();
        logic [31:0] av, bv;
        logic        c;
        logic [32:0] e;
        int          n, first, hs0;
        hs0 = hs32;
        for (int k = 0; k < 12; k++) begin
            av = (k == 0) ? 32'hFFFF_FFFF : 32'($urandom);
            bv = (k == 0) ? 32'h0000_0000 : 32'($urandom);
            c  = (k == 0) ? 1'b1 : 1'($urandom);
            e  = {1'b0, av} + {1'b0, bv} + {32'b0, c};
            in_valid32 = 1'b1; a32 = av; b32 = bv; cin32 = c;
            tick();
            in_valid32 = 1'b0; a32 = ~av; cin32 = ~c;
            n = 0;
            first = -1;
            while (n < 200) begin
                out_ready32 = 1'($urandom);
                if (out_valid32 === 1'b1) begin
                    if (first < 0) first = n;
                    if (out_ready32) break;
                end
                tick();
                n++;
            end
            checks++;
            if (first != 8 || {cout32, sum32} !== e) begin
                errors++;
                $display("FAIL w32_txn: txn=%0d cycles=%0d got=%h expected 8 %h", k, first, {cout32, sum32}, e);
            end
            tick();
            checks++;
            if (out_valid32 !== 1'b0 || busy32 !== 1'b0 || in_ready32 !== 1'b1) begin
                errors++;
                $display("FAIL w32_dup: txn=%0d out_valid=%b busy=%b in_ready=%b expected 0 0 1",
                         k, out_valid32, busy32, in_ready32);
            end
        end
        checks++;
        if (hs32 - hs0 != 12) begin
            errors++;
            $display("FAIL w32_count: handshakes=%0d expected 12", hs32 - hs0);
        end
    endtask

    initial begin
        test_reset();
        test_carry_ripple();
        test_carry_in();
        test_backpressure();
        test_reset_mid_run();
`ifdef CLA_MWADD_SUB_EN
        test_sub();
`endif
        test_back_to_back16();
        test_width4();
        test_width32();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
